// File: rtl/hwag_wheel_gen.sv
// Crank trigger-wheel generator: TOOTH_NUM-GAP_NUM tooth pattern with programmable pitch and
// high time, plus tooth index, once-per-revolution strobe and busy flag.
//   state | meaning
//   IDLE  | output inactive, waiting for ena
//   RUN   | emitting teeth
//   STOP  | ena dropped; finishing the current tooth before returning to IDLE
module hwag_wheel_gen #(
  parameter int TOOTH_NUM = 60,
  parameter int GAP_NUM   = 2,
  parameter int PERIOD_W  = 16,
  parameter int IDX_W     = $clog2(TOOTH_NUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] high_len,
  input  logic                pol,
  output logic                tooth_out,
  output logic [IDX_W-1:0]    tooth_idx,
  output logic                rev_strobe,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(TOOTH_NUM - 1);
  localparam logic [IDX_W-1:0]    IDX_GAP  = IDX_W'(TOOTH_NUM - GAP_NUM);
  localparam logic [PERIOD_W-1:0] P_MIN    = PERIOD_W'(2);
  localparam logic [PERIOD_W-1:0] ONE      = PERIOD_W'(1);

  state_t                state_q, state_d;
  logic [PERIOD_W-1:0]   tick_q, tick_d;
  logic [PERIOD_W-1:0]   p_q, p_d, h_q, h_d;
  logic [PERIOD_W-1:0]   p_san, h_san;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  raw_q, raw_d;
  logic                  rev_q, rev_d;
  logic                  pend_q, pend_d;

  // Clamp so every tooth has at least one high and one low tick.
  always_comb begin
    p_san = (period < P_MIN) ? P_MIN : period;
    if (high_len == '0)
      h_san = ONE;
    else if (high_len > p_san - ONE)
      h_san = p_san - ONE;
    else
      h_san = high_len;
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    p_d     = p_q;
    h_d     = h_q;
    pend_d  = pend_q;
    raw_d   = 1'b0;
    rev_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena) begin
          state_d = RUN;
          p_d     = p_san;
          h_d     = h_san;
          tick_d  = '0;
          idx_d   = '0;
          pend_d  = 1'b1;
        end
      end
      default: begin
        state_d = ena ? RUN : STOP;
        // pend_q marks the one-clock start latency before tooth 0 begins
        if (pend_q) begin
          pend_d = 1'b0;
          tick_d = '0;
          idx_d  = '0;
        end else if (tick_q == p_q - ONE) begin
          tick_d = '0;
          if (!ena) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            p_d   = p_san;
            h_d   = h_san;
          end
        end else begin
          tick_d = tick_q + ONE;
        end
        if (state_d != IDLE) begin
          raw_d = (tick_d < h_d) && (idx_d < IDX_GAP);
          rev_d = (tick_d == '0) && (idx_d == '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      p_q     <= P_MIN;
      h_q     <= ONE;
      raw_q   <= 1'b0;
      rev_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      p_q     <= p_d;
      h_q     <= h_d;
      raw_q   <= raw_d;
      rev_q   <= rev_d;
      pend_q  <= pend_d;
    end
  end

  assign tooth_out  = raw_q ^ pol;
  assign tooth_idx  = idx_q;
  assign rev_strobe = rev_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_hwag_wheel_gen.sv
// Scoreboard bench for hwag_wheel_gen: a tooth-level model expands each tooth into expected
// per-cycle outputs; an independent monitor compares them against the DUT.
module tb_hwag_wheel_gen;
  localparam int TN = 6;
  localparam int GN = 1;
  localparam int PW = 16;
  localparam int IW = $clog2(TN);

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic [PW-1:0] period;
  logic [PW-1:0] high_len;
  logic          pol;
  logic          tooth_out;
  logic [IW-1:0] tooth_idx;
  logic          rev_strobe;
  logic          busy;

  hwag_wheel_gen #(.TOOTH_NUM(TN), .GAP_NUM(GN), .PERIOD_W(PW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .period(period), .high_len(high_len), .pol(pol),
    .tooth_out(tooth_out), .tooth_idx(tooth_idx), .rev_strobe(rev_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic          out;
    logic [IW-1:0] idx;
    logic          rev;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   s, cur_i, cur_p, cur_h;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle the wheel presents a sample; compare those the model predicted.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      vectors++;
      if (e.cyc != cyc || tooth_out !== e.out || tooth_idx !== e.idx ||
          rev_strobe !== e.rev || busy !== e.busy) begin
        miscompares++;
        $display("FAIL wave cyc=%0d(exp %0d) out/idx/rev/busy got %b/%0d/%b/%b want %b/%0d/%b/%b",
                 cyc, e.cyc, tooth_out, tooth_idx, rev_strobe, busy, e.out, e.idx, e.rev, e.busy);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  function automatic int san_p(int per);
    return (per < 2) ? 2 : per;
  endfunction

  function automatic int san_h(int per, int hl);
    int p = san_p(per);
    if (hl == 0) return 1;
    return (hl < p) ? hl : p - 1;
  endfunction

  task automatic push(int c, logic o, int i, logic r, logic b);
    exp_t e;
    e.cyc = c; e.out = o; e.idx = IW'(i); e.rev = r; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic push_tooth(int st, int i, int p, int h);
    for (int t = 0; t < p; t++)
      push(st + t, logic'((t < h) && (i < TN - GN)) ^ pol, i, (t == 0) && (i == 0), 1'b1);
  endtask

  // Leaves the caller at negedge+1 of cycle x (inputs set here are seen by edge x+1).
  task automatic wait_cyc(int x);
    if (cyc < x) begin
      while (cyc < x) @(negedge clk);
      #1;
    end
  endtask

  task automatic start_run();
    ena   = 1'b1;
    cur_p = san_p(int'(period));
    cur_h = san_h(int'(period), int'(high_len));
    push(cyc + 1, pol, 0, 1'b0, 1'b1);
    s     = cyc + 2;
    cur_i = 0;
  endtask

  // act: 0 keep inputs, 1 new inputs, 2 stop then restart, 3 stop then resume within the tooth
  task automatic tooth(int act, int np, int nh, int ta);
    int t2, k;
    push_tooth(s, cur_i, cur_p, cur_h);
    wait_cyc(s + ta);
    if (act != 0) begin
      period   = PW'(np);
      high_len = PW'(nh);
    end
    if (act >= 2) ena = 1'b0;
    if (act == 3) begin
      t2 = $urandom_range(ta + 1, cur_p - 1);
      wait_cyc(s + t2);
      ena = 1'b1;
    end
    if (act == 2) begin
      k = $urandom_range(0, 3);
      for (int c = s + cur_p; c <= s + cur_p + k; c++) push(c, pol, 0, 1'b0, 1'b0);
      wait_cyc(s + cur_p + k);
      pol = 1'($urandom_range(0, 1));
      start_run();
    end else begin
      s     = s + cur_p;
      cur_i = (cur_i + 1) % TN;
      cur_p = san_p(int'(period));
      cur_h = san_h(int'(period), int'(high_len));
    end
  endtask

  task automatic rand_tooth();
    int r, np, nh, act, ta;
    r  = $urandom_range(0, 19);
    np = $urandom_range(0, 9);
    nh = $urandom_range(0, 11);
    act = (r < 10) ? 0 : (r < 17) ? 1 : (r == 17) ? 2 : 3;
    ta = (act == 3) ? $urandom_range(0, cur_p - 2) : $urandom_range(0, cur_p - 1);
    tooth(act, np, nh, ta);
  endtask

  task automatic direct_check(string name, logic o, logic [IW-1:0] i, logic b);
    vectors++;
    if (tooth_out !== o || tooth_idx !== i || busy !== b) begin
      miscompares++;
      $display("FAIL %s out/idx/busy got %b/%0d/%b want %b/%0d/%b",
               name, tooth_out, tooth_idx, busy, o, i, b);
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; period = PW'(4); high_len = PW'(2); pol = 1'b0;
    @(negedge clk); #1;
    direct_check("reset_state", 1'b0, '0, 1'b0);
    vectors++;
    if (rev_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rev got %b want 0", rev_strobe);
    end
    rst = 1'b0;

    // 6-1 wheel, pitch 4, high 2: two full revolutions
    start_run();
    for (int n = 0; n < 2 * TN; n++) tooth(0, 0, 0, 0);

    // pitch change 4->8 at tick 1 of tooth 2
    tooth(0, 0, 0, 0);
    tooth(0, 0, 0, 0);
    tooth(1, 8, 5, 1);
    tooth(0, 0, 0, 0);

    // sanitising: period 0/1, high_len 0, high_len beyond pitch
    tooth(1, 0, 3, 0);
    tooth(1, 1, 0, 0);
    tooth(1, 4, 9, 0);
    tooth(1, 4, 0, 0);
    tooth(1, 4, 2, 0);
    tooth(0, 0, 0, 0);

    // stop at tick 1 of tooth 3, then restart
    while (cur_i != 3) tooth(0, 0, 0, 0);
    tooth(2, 4, 2, 1);
    for (int n = 0; n < 4; n++) tooth(0, 0, 0, 0);

    // ena dropped and restored within tooth 3: seamless continuation
    while (cur_i != 3) tooth(0, 0, 0, 0);
    tooth(3, 6, 3, 0);
    for (int n = 0; n < 3; n++) tooth(0, 0, 0, 0);

    // asynchronous reset in the high phase of tooth 1
    while (cur_i != 1) tooth(0, 0, 0, 0);
    push_tooth(s, cur_i, cur_p, cur_h);
    wait_cyc(s);
    #2 rst = 1'b1;
    #1 direct_check("async_reset", pol, '0, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    start_run();
    for (int n = 0; n < 8; n++) tooth(0, 0, 0, 0);

    for (int n = 0; n < 200; n++) rand_tooth();

    for (int w = 0; w < 200 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
